// File: rtl/wb_rr_conbus.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, round-robin grant,
// address-field slave decode, per-transfer watchdog and error response.
module wb_rr_conbus #(
    parameter int NM      = 4,
    parameter int NS      = 8,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SEL_HI  = 31,
    parameter int SEL_LO  = 28,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NM*DW-1:0]      m_dat_i,
    input  logic [NM*AW-1:0]      m_adr_i,
    input  logic [NM*(DW/8)-1:0]  m_sel_i,
    input  logic [NM-1:0]         m_we_i,
    input  logic [NM-1:0]         m_stb_i,
    output logic [NM*DW-1:0]      m_dat_o,
    output logic [NM-1:0]         m_ack_o,
    output logic [NM-1:0]         m_err_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic [NS-1:0]         s_stb_o,
    input  logic [NS*DW-1:0]      s_dat_i,
    input  logic [NS-1:0]         s_ack_i,
    output logic [NM-1:0]         gnt_o
);
    localparam int SW = DW / 8;
    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int XW = SEL_HI - SEL_LO + 1;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state_reg, state_next;
    logic [MW-1:0] gnt_reg, gnt_next;
    logic [MW-1:0] ptr_reg, ptr_next;
    logic [15:0]   wd_reg, wd_next;

    logic [AW-1:0] adr_mux;
    logic [DW-1:0] dat_mux;
    logic [DW-1:0] rdat_mux;
    logic [SW-1:0] sel_mux;
    logic          we_mux;
    logic          stb_mux;
    logic [XW-1:0] idx;
    logic [NS-1:0] slave_hit;
    logic          mapped;
    logic          ack_mux;

    // Granted master's request; gnt_reg always points at a valid master.
    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        we_mux  = 1'b0;
        stb_mux = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (gnt_reg == MW'(k)) begin
                adr_mux = m_adr_i[k*AW +: AW];
                dat_mux = m_dat_i[k*DW +: DW];
                sel_mux = m_sel_i[k*SW +: SW];
                we_mux  = m_we_i[k];
                stb_mux = m_stb_i[k];
            end
        end
    end

    assign idx     = adr_mux[SEL_HI:SEL_LO];
    assign s_adr_o = adr_mux;
    assign s_dat_o = dat_mux;
    assign s_sel_o = sel_mux;
    assign s_we_o  = we_mux;

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slave
            assign slave_hit[gi] = (state_reg == BUSY) && (idx == XW'(gi));
            assign s_stb_o[gi]   = slave_hit[gi] && stb_mux;
        end
    endgenerate

    assign mapped = |slave_hit;

    always_comb begin
        rdat_mux = '0;
        ack_mux  = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (slave_hit[j]) begin
                rdat_mux = s_dat_i[j*DW +: DW];
                ack_mux  = s_ack_i[j];
            end
        end
    end

    // ack_mux and rdat_mux are zero outside BUSY, so late slave acks never leak through.
    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_master
            logic owned;
            assign owned                 = (gnt_reg == MW'(gi));
            assign gnt_o[gi]             = owned && (state_reg != IDLE);
            assign m_ack_o[gi]           = owned && ack_mux && stb_mux;
            assign m_err_o[gi]           = owned && (state_reg == ERR);
            assign m_dat_o[gi*DW +: DW]  = owned ? rdat_mux : '0;
        end
    endgenerate

    always_comb begin : p_fsm
        int win;
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        wd_next    = '0;
        win        = 0;
        case (state_reg)
            IDLE: begin
                if (|m_stb_i) begin
                    // Descending scan so the nearest requester at/after the pointer wins.
                    for (int i = NM - 1; i >= 0; i--) begin
                        if (m_stb_i[(int'(ptr_reg) + i) % NM]) begin
                            win = (int'(ptr_reg) + i) % NM;
                        end
                    end
                    gnt_next   = MW'(win);
                    ptr_next   = MW'((win + 1) % NM);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!stb_mux) begin
                    state_next = IDLE;
                end else if (!mapped) begin
                    state_next = ERR;
                end else if (ack_mux) begin
                    state_next = IDLE;
                end else if (wd_reg == 16'(TIMEOUT - 1)) begin
                    state_next = ERR;
                end else begin
                    wd_next = wd_reg + 16'd1;
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ptr_reg   <= '0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ptr_reg   <= ptr_next;
            wd_reg    <= wd_next;
        end
    end
endmodule

// File: tb/tb_wb_rr_conbus.sv
// Bench for wb_rr_conbus: transaction-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_wb_rr_conbus;
    localparam int NM  = 4;
    localparam int NS  = 6;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NM*DW-1:0]  m_dat = '0;
    logic [NM*AW-1:0]  m_adr = '0;
    logic [NM*4-1:0]   m_sel = '0;
    logic [NM-1:0]     m_we = '0;
    logic [NM-1:0]     m_stb = '0;
    logic [NM*DW-1:0]  m_rdat;
    logic [NM-1:0]     m_ack, m_err, gnt;
    logic [DW-1:0]     s_dat;
    logic [AW-1:0]     s_adr;
    logic [3:0]        s_sel;
    logic              s_we;
    logic [NS-1:0]     s_stb;
    logic [NS*DW-1:0]  s_rdat;
    logic [NS-1:0]     s_ack;
    logic [NS-1:0]     ack_mask = '1;
    logic [NS-1:0]     force_ack = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Zero-wait slaves gated by ack_mask; force_ack injects acks unrelated to any strobe.
    assign s_ack = (s_stb & ack_mask) | force_ack;

    always #5 clk = ~clk;

    wb_rr_conbus #(
        .NM(NM), .NS(NS), .DW(DW), .AW(AW),
        .SEL_HI(31), .SEL_LO(28), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_dat_i(m_dat), .m_adr_i(m_adr), .m_sel_i(m_sel), .m_we_i(m_we), .m_stb_i(m_stb),
        .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_dat_o(s_dat), .s_adr_o(s_adr), .s_sel_o(s_sel), .s_we_o(s_we), .s_stb_o(s_stb),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] adr, input logic we, input logic [31:0] dat);
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_sel[k*4 +: 4]   = 4'hF;
        m_we[k]           = we;
        m_stb[k]          = 1'b1;
    endtask

    task automatic clear_req(input int k);
        m_stb[k] = 1'b0;
        m_we[k]  = 1'b0;
    endtask

    // Model: who owns the bus, whether an error response is due, how long it has waited.
    int  owner = -1;
    int  ptr = 0;
    int  busy_cycles = 0;
    bit  err_pend = 1'b0;
    int  slv = 0;
    logic [31:0]      cur_adr;
    logic [NM-1:0]    e_gnt, e_ack, e_err;
    logic [NS-1:0]    e_stb;
    logic [NM*DW-1:0] e_dat;

    always @(negedge clk) begin
        e_gnt = '0; e_ack = '0; e_err = '0; e_stb = '0; e_dat = '0;
        slv = 0;
        if (rst_n && owner >= 0) begin
            e_gnt[owner] = 1'b1;
            if (err_pend) begin
                e_err[owner] = 1'b1;
            end else begin
                cur_adr = m_adr[owner*AW +: AW];
                slv = int'(cur_adr[31:28]);
                if (slv < NS) begin
                    e_dat[owner*DW +: DW] = s_rdat[slv*DW +: DW];
                    if (m_stb[owner]) e_stb[slv] = 1'b1;
                    if (m_stb[owner] && s_ack[slv]) e_ack[owner] = 1'b1;
                end
            end
        end
        check("gnt", gnt, e_gnt);
        check("s_stb", s_stb, e_stb);
        check("m_ack", m_ack, e_ack);
        check("m_err", m_err, e_err);
        check("m_dat", m_rdat, e_dat);
        if (rst_n && owner >= 0) check("s_adr", s_adr, m_adr[owner*AW +: AW]);
        if (e_ack != 0) $display("%0t: master %0d ack slave %0d", $time, owner, slv);
        if (e_err != 0) $display("%0t: master %0d err", $time, owner);

        if (!rst_n) begin
            owner = -1; ptr = 0; busy_cycles = 0; err_pend = 1'b0;
        end else if (owner < 0) begin
            for (int i = 0; i < NM; i++)
                if (owner < 0 && m_stb[(ptr + i) % NM]) owner = (ptr + i) % NM;
            if (owner >= 0) begin
                ptr = (owner + 1) % NM;
                busy_cycles = 0;
                err_pend = 1'b0;
            end
        end else if (err_pend) begin
            owner = -1;
            err_pend = 1'b0;
        end else if (!m_stb[owner] || e_ack != 0) begin
            owner = -1;
        end else if (slv >= NS) begin
            err_pend = 1'b1;
        end else if (busy_cycles + 1 == TMO) begin
            err_pend = 1'b1;
        end else begin
            busy_cycles++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[$];
        int stb_cycles;
        bit got;

        for (int j = 0; j < NS; j++) s_rdat[j*DW +: DW] = 32'hA000_0000 + 32'(j);
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_stb", s_stb, 6'b000000);
        check("rst_ack_err", {m_ack, m_err}, 8'h00);
        rst_n = 1'b1;

        // 1: single master write to slave 1
        tick();
        set_req(0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_stb", s_stb, 6'b000010);
        check("t1_ack", m_ack, 4'b0001);
        check("t1_wdat", s_dat, 32'hDEAD_BEEF);
        check("t1_we", s_we, 1'b1);
        check("t1_rdat", m_rdat[31:0], 32'hA000_0001);
        clear_req(0);
        tick();
        check("t1_gnt_idle", gnt, 4'b0000);
        check("t1_ack_idle", m_ack, 4'b0000);

        // 2: four continuous requesters after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NM; k++) set_req(k, 32'h0000_0100 + 32'(k), 1'b0, 32'h0);
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int k = 0; k < NM; k++) if (gnt[k]) order.push_back(k);
        end
        for (int k = 0; k < NM; k++) clear_req(k);
        check("t2_count", order.size(), 8);
        for (int i = 0; i < 8; i++) check("t2_order", (i < order.size()) ? order[i] : -1, i % 4);

        // 3: unmapped slave index
        tick();
        set_req(2, 32'hF000_0000, 1'b0, 32'h0);
        tick();
        check("t3_gnt", gnt, 4'b0100);
        check("t3_nostb", s_stb, 6'b000000);
        check("t3_noerr_yet", m_err, 4'b0000);
        tick();
        check("t3_err", m_err, 4'b0100);
        clear_req(2);
        tick();
        check("t3_err_once", m_err, 4'b0000);

        // 4: slave never acks, watchdog fires
        ack_mask = '0;
        set_req(1, 32'h3000_0000, 1'b1, 32'h1234_5678);
        stb_cycles = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (s_stb[3]) stb_cycles++;
            if (m_err != 0) begin
                got = 1'b1;
                check("t4_err", m_err, 4'b0010);
            end
        end
        check("t4_err_seen", got, 1'b1);
        check("t4_busy_cycles", stb_cycles, TMO);
        clear_req(1);
        ack_mask = '1;
        tick();
        set_req(0, 32'h0000_0010, 1'b0, 32'h0);
        set_req(1, 32'h0000_0020, 1'b0, 32'h0);
        tick();
        check("t4_next_gnt", gnt, 4'b0001);
        clear_req(0);
        clear_req(1);
        tick();

        // 5: m1 aborts, m3 follows
        ack_mask = 6'b111011;
        set_req(1, 32'h2000_0000, 1'b0, 32'h0);
        set_req(3, 32'h2000_0008, 1'b0, 32'h0);
        tick();
        check("t5_gnt", gnt, 4'b0010);
        check("t5_stb", s_stb, 6'b000100);
        tick();
        clear_req(1);
        #1;
        check("t5_stb_drop", s_stb, 6'b000000);
        tick();
        check("t5_idle", {gnt, m_ack, m_err}, 12'h000);
        tick();
        check("t5_m3_gnt", gnt, 4'b1000);
        check("t5_m3_adr", s_adr, 32'h2000_0008);
        ack_mask = '1;
        #1;
        check("t5_m3_ack", m_ack, 4'b1000);
        clear_req(3);
        tick();

        // late ack outside a transfer
        force_ack = '1;
        tick();
        check("late_ack", m_ack, 4'b0000);
        force_ack = '0;
        tick();

        // 6: reset during a transfer awaiting ack
        ack_mask = 6'b111101;
        set_req(2, 32'h1000_0000, 1'b0, 32'h0);
        tick();
        check("t6_gnt", gnt, 4'b0100);
        set_req(0, 32'h1000_0004, 1'b0, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 4'b0000);
        check("t6_rst_stb", s_stb, 6'b000000);
        check("t6_rst_ackerr", {m_ack, m_err}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_m0_first", gnt, 4'b0001);
        ack_mask = '1;
        #1;
        check("t6_m0_ack", m_ack, 4'b0001);
        clear_req(0);
        clear_req(2);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
